// File: rtl/xge_pkt_gen_pkg.sv
// Shared types and helpers for the xge_mac transmit traffic generator
// and its payload LFSR.
package xge_pkt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, with the x^32 term implied by the shift-out bit
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] words_for_len(input logic [31:0] len,
                                                input int unsigned bytes);
    return (len + bytes - 32'd1) / bytes;
  endfunction

endpackage

// File: rtl/xge_pkt_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enables; load wins.
// The current state is presented combinationally from the state register.
module xge_pkt_gen_lfsr
  import xge_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 32'h1;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/xge_pkt_gen.sv
// Burst packet generator for the xge_mac pkt_tx port: first word one cycle after
// command accept; pkt_tx_full stalls the word stream in place, the gap timer keeps running.
module xge_pkt_gen
  import xge_pkt_gen_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 14,
  parameter int CNT_W  = 32
) (
  input  logic                        clk_156m25,
  input  logic                        reset_156m25,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic [15:0]                 cmd_count,
  input  logic [7:0]                  cmd_ipg,
  input  logic [31:0]                 cmd_seed,
  input  logic                        abort,
  input  logic                        stats_clr,
  input  logic                        pkt_tx_full,
  output logic                        pkt_tx_val,
  output logic                        pkt_tx_sop,
  output logic                        pkt_tx_eop,
  output logic [$clog2(DATA_W/8)-1:0] pkt_tx_mod,
  output logic [DATA_W-1:0]           pkt_tx_data,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_sent,
  output logic [CNT_W-1:0]            byte_sent
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int          MOD_W = $clog2(BYTES);
  localparam int          LANES = DATA_W / 32;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_cmd_rdy;
  logic               r_busy;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_last_idx;
  logic [LEN_W-1:0]   r_idx;
  logic [15:0]        r_cnt;
  logic [7:0]         r_ipg;
  logic [7:0]         r_gap;
  logic               r_abort_seen;

  logic               r_val;
  logic               r_sop;
  logic               r_eop;
  logic [MOD_W-1:0]   r_mod;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_pkt_sent;
  logic [CNT_W-1:0]   r_byte_sent;

  logic               w_accept;
  logic               w_emit;
  logic               w_last;
  logic               w_eop;
  logic               w_abort_hit;
  logic [31:0]        w_words;
  logic [31:0]        w_seed;
  logic [31:0]        w_lfsr;
  logic [DATA_W-1:0]  w_lanes;
  logic [MOD_W-1:0]   w_len_mod;
  logic [CNT_W-1:0]   w_len_c;

  assign w_accept    = cmd_valid & r_cmd_rdy;
  assign w_emit      = (r_state == ST_SEND) & ~pkt_tx_full;
  assign w_last      = (r_idx == r_last_idx);
  assign w_eop       = w_emit & w_last;
  assign w_abort_hit = r_abort_seen | abort;
  assign w_words     = words_for_len(32'(cmd_len), BYTES);
  assign w_seed      = (cmd_seed == 32'h0) ? 32'h1 : cmd_seed;
  assign w_len_mod   = MOD_W'(r_len % LEN_W'(BYTES));
  assign w_len_c     = CNT_W'(r_len);

  xge_pkt_gen_lfsr u_lfsr (
    .clk     (clk_156m25),
    .rst     (reset_156m25),
    .i_load  (w_accept),
    .i_seed  (w_seed),
    .i_step  (w_emit),
    .o_state (w_lfsr)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lanes[32*k +: 32] = w_lfsr ^ 32'(k);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (cmd_len != '0) && (cmd_count != 16'd0)) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_eop) begin
          if ((r_cnt == 16'd1) || w_abort_hit) begin
            w_state_nxt = ST_IDLE;
          end else if (r_ipg == 8'd0) begin
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap == 8'd0) begin
          w_state_nxt = ST_SEND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_state   <= ST_IDLE;
      r_cmd_rdy <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_rdy <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // The gap timer is loaded with ipg-1 on eop so GAP occupies exactly ipg edges.
  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_len      <= '0;
      r_last_idx <= '0;
      r_idx      <= '0;
      r_cnt      <= 16'd0;
      r_ipg      <= 8'd0;
      r_gap      <= 8'd0;
    end else if (w_accept) begin
      r_len      <= cmd_len;
      r_last_idx <= LEN_W'(w_words - 32'd1);
      r_idx      <= '0;
      r_cnt      <= cmd_count;
      r_ipg      <= cmd_ipg;
    end else if (w_emit) begin
      if (w_last) begin
        r_idx <= '0;
        r_cnt <= r_cnt - 16'd1;
        r_gap <= r_ipg - 8'd1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else if ((r_state == ST_GAP) && (r_gap != 8'd0)) begin
      r_gap <= r_gap - 8'd1;
    end
  end

  // Abort is remembered until the packet in flight reaches eop.
  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_abort_seen <= 1'b0;
    end else if (r_state == ST_SEND) begin
      if (w_eop) begin
        r_abort_seen <= 1'b0;
      end else if (abort) begin
        r_abort_seen <= 1'b1;
      end
    end else begin
      r_abort_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_val  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_mod  <= '0;
      r_data <= '0;
    end else begin
      r_val <= w_emit;
      r_sop <= w_emit & (r_idx == '0);
      r_eop <= w_eop;
      r_mod <= w_eop ? w_len_mod : '0;
      if (w_emit) begin
        r_data <= w_lanes;
      end
    end
  end

  // A clear that lands on an eop keeps that packet's contribution.
  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_pkt_sent  <= '0;
      r_byte_sent <= '0;
    end else if (w_eop) begin
      r_pkt_sent  <= stats_clr ? CNT_W'(1) : r_pkt_sent + CNT_W'(1);
      r_byte_sent <= stats_clr ? w_len_c : r_byte_sent + w_len_c;
    end else if (stats_clr) begin
      r_pkt_sent  <= '0;
      r_byte_sent <= '0;
    end
  end

  assign cmd_ready   = r_cmd_rdy;
  assign busy        = r_busy;
  assign pkt_tx_val  = r_val;
  assign pkt_tx_sop  = r_sop;
  assign pkt_tx_eop  = r_eop;
  assign pkt_tx_mod  = r_mod;
  assign pkt_tx_data = r_data;
  assign pkt_sent    = r_pkt_sent;
  assign byte_sent   = r_byte_sent;

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Scoreboarded bench for xge_pkt_gen: a queue-based reference model of each burst
// is checked word by word by an independent monitor, plus directed timing checks.
module tb_xge_pkt_gen;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 14;
  localparam int CNT_W  = 8;
  localparam int BYTES  = DATA_W / 8;
  localparam int MOD_W  = $clog2(BYTES);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [15:0]       cmd_count = '0;
  logic [7:0]        cmd_ipg = '0;
  logic [31:0]       cmd_seed = '0;
  logic              abort = 1'b0;
  logic              stats_clr = 1'b0;
  logic              pkt_tx_full;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic [DATA_W-1:0] pkt_tx_data;
  logic              busy;
  logic [CNT_W-1:0]  pkt_sent, byte_sent;

  logic full_force = 1'b0;
  logic rnd_en = 1'b0;
  logic rnd_bit = 1'b0;
  assign pkt_tx_full = full_force | (rnd_en & rnd_bit);

  always #3 clk = ~clk;

  xge_pkt_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_156m25   (clk),
    .reset_156m25 (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_count    (cmd_count),
    .cmd_ipg      (cmd_ipg),
    .cmd_seed     (cmd_seed),
    .abort        (abort),
    .stats_clr    (stats_clr),
    .pkt_tx_full  (pkt_tx_full),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_data  (pkt_tx_data),
    .busy         (busy),
    .pkt_sent     (pkt_sent),
    .byte_sent    (byte_sent)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    int                gap;
  } word_t;

  word_t       exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned m_pkts = 0;
  int unsigned m_bytes = 0;
  int          idle_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Multiplication by x modulo the generator polynomial.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ 33'h1_0040_0007;
    return t[31:0];
  endfunction

  task automatic push_burst(input int len, input int n_pkts, input int ipg,
                            input logic [31:0] seed, input bit chk_gap);
    logic [31:0] l;
    word_t       w;
    int          nw;
    l  = (seed == 32'h0) ? 32'h1 : seed;
    nw = (len + BYTES - 1) / BYTES;
    for (int p = 0; p < n_pkts; p++) begin
      for (int i = 0; i < nw; i++) begin
        for (int k = 0; k < DATA_W / 32; k++) w.data[32*k +: 32] = l ^ k;
        w.sop = (i == 0);
        w.eop = (i == nw - 1);
        w.mod = w.eop ? MOD_W'(len % BYTES) : '0;
        w.gap = (i == 0 && p > 0 && chk_gap) ? ipg : -1;
        exp_q.push_back(w);
        l = ref_step(l);
      end
    end
    m_pkts  += n_pkts;
    m_bytes += n_pkts * len;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rnd_bit = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin : monitor
    word_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle_run = 0;
      end else if (pkt_tx_val) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%0h, expected no word", pkt_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", pkt_tx_data, e.data);
          check("word_sop", pkt_tx_sop, e.sop);
          check("word_eop", pkt_tx_eop, e.eop);
          check("word_mod", pkt_tx_mod, e.mod);
          if (e.gap >= 0) check("ipg_idle_cycles", idle_run, e.gap);
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  task automatic send_cmd(input int len, input int cnt, input int ipg,
                          input logic [31:0] seed, input bit chk_lat);
    int i = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_count = 16'(cnt);
    cmd_ipg   = 8'(ipg);
    cmd_seed  = seed;
    while (!cmd_ready && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (chk_lat) begin
      check("busy_after_accept", busy, 1);
      check("no_word_at_accept", pkt_tx_val, 0);
      @(negedge clk);
      check("first_word_latency", {pkt_tx_val, pkt_tx_sop}, 2'b11);
    end
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, (busy || exp_q.size() != 0), 0);
    @(negedge clk);
    check({tag, "_pkt_sent"}, pkt_sent, m_pkts[CNT_W-1:0]);
    check({tag, "_byte_sent"}, byte_sent, m_bytes[CNT_W-1:0]);
  endtask

  task automatic clr_stats();
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    m_pkts  = 0;
    m_bytes = 0;
    check("stats_clr_pkt", pkt_sent, 0);
    check("stats_clr_byte", byte_sent, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d words still expected", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, cnt, ipg;
    logic [31:0] seed;
    bit stall;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_val", pkt_tx_val, 0);
    check("rst_sop_eop", {pkt_tx_sop, pkt_tx_eop}, 0);
    check("rst_mod", pkt_tx_mod, 0);
    check("rst_data", pkt_tx_data, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_counters", {pkt_sent, byte_sent}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    push_burst(64, 1, 0, 32'h1, 1);
    send_cmd(64, 1, 0, 32'h1, 1);
    wait_done("single64");

    clr_stats();
    push_burst(65, 3, 4, 32'hDEAD_BEEF, 1);
    send_cmd(65, 3, 4, 32'hDEAD_BEEF, 1);
    wait_done("len65_ipg4");

    push_burst(5, 2, 0, 32'h1234_5678, 1);
    send_cmd(5, 2, 0, 32'h1234_5678, 1);
    wait_done("len5_b2b");

    send_cmd(0, 3, 0, 32'h5, 0);
    check("len0_not_busy", busy, 0);
    check("len0_cmd_ready", cmd_ready, 1);
    send_cmd(16, 0, 0, 32'h5, 0);
    check("cnt0_not_busy", busy, 0);

    push_burst(64, 1, 0, 32'h0BAD_F00D, 1);
    send_cmd(64, 1, 0, 32'h0BAD_F00D, 1);
    repeat (2) @(negedge clk);
    full_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_val_low", pkt_tx_val, 0);
    end
    full_force = 1'b0;
    @(negedge clk);
    check("stall_resume_val", pkt_tx_val, 1);
    wait_done("stall");

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_no_effect", {busy, cmd_ready}, 2'b01);

    clr_stats();
    push_burst(64, 1, 2, 32'hA5A5_0001, 1);
    send_cmd(64, 10, 2, 32'hA5A5_0001, 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    repeat (10) @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_pkt_sent", pkt_sent, 1);

    for (int it = 0; it < 12; it++) begin
      len   = $urandom_range(1, 40);
      cnt   = $urandom_range(1, 4);
      ipg   = $urandom_range(0, 3);
      seed  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      stall = it[0];
      push_burst(len, cnt, ipg, seed, !stall);
      rnd_en = stall;
      send_cmd(len, cnt, ipg, seed, 0);
      wait_done("random");
      rnd_en = 1'b0;
    end

    clr_stats();
    push_burst(1, 254, 0, 32'h7, 1);
    send_cmd(1, 254, 0, 32'h7, 1);
    wait_done("preload");
    push_burst(64, 2, 0, 32'h9, 1);
    send_cmd(64, 2, 0, 32'h9, 1);
    wait_done("wrap");
    check("wrap_pkt_zero", pkt_sent, 0);

    push_burst(64, 1, 0, 32'h11, 1);
    send_cmd(64, 1, 0, 32'h11, 1);
    repeat (6) @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("clr_on_eop_word", pkt_tx_eop, 1);
    m_pkts  = 1;
    m_bytes = 64;
    wait_done("clr_on_eop");

    push_burst(64, 1, 0, 32'h22, 1);
    send_cmd(64, 1, 0, 32'h22, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_val", pkt_tx_val, 0);
    check("midrst_busy", busy, 0);
    check("midrst_counters", {pkt_sent, byte_sent}, 0);
    exp_q.delete();
    m_pkts  = 0;
    m_bytes = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1);
    push_burst(12, 2, 1, 32'h33, 1);
    send_cmd(12, 2, 1, 32'h33, 1);
    wait_done("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
